// File: rtl/tcam28x64_search_array.sv
// tcam28x64_search_array: SRAM-based TCAM search, four 7-bit key slices index 128x64 match-vector banks, ANDed and priority-encoded.
module tcam28x64_search_array #(
  parameter int NUM_BLOCKS = 4,
  parameter int ENTRIES    = 64
) (
  input  logic                       in_clk,
  input  logic                       in_rstn,
  input  logic                       in_csb,
  input  logic                       in_web,
  input  logic [3:0]                 in_wmask,
  input  logic [7*NUM_BLOCKS-1:0]    in_addr,
  input  logic [31:0]                in_wdata,
  output logic [$clog2(ENTRIES)-1:0] out_pma,
  output logic                       out_hit
);
  logic [ENTRIES-1:0] r_mem [NUM_BLOCKS][128];
  logic [ENTRIES-1:0] r_rd  [NUM_BLOCKS];
  logic [7:0]         w_be;
  logic [63:0]        w_wd;
  logic [ENTRIES-1:0] w_m;
  logic               w_wr;
  logic               w_rd;
  assign w_wr = !in_csb && !in_web;
  assign w_rd = !in_csb && in_web;
  assign w_be = in_addr[7] ? {in_wmask, 4'b0} : {4'b0, in_wmask};
  assign w_wd = {in_wdata, in_wdata};
  // storage has no reset; in_rstn only blocks writes issued while reset is held
  always_ff @(posedge in_clk)
    if (in_rstn && w_wr)
      for (int k = 0; k < 8; k++)
        if (w_be[k]) r_mem[in_addr[9:8]][in_addr[6:0]][8*k +: 8] <= w_wd[8*k +: 8];
  always_ff @(posedge in_clk or negedge in_rstn)
    if (!in_rstn)
      for (int b = 0; b < NUM_BLOCKS; b++) r_rd[b] <= '0;
    else if (w_rd)
      for (int b = 0; b < NUM_BLOCKS; b++) r_rd[b] <= r_mem[b][in_addr[7*b +: 7]];
  always_comb begin
    w_m = '1;
    for (int b = 0; b < NUM_BLOCKS; b++) w_m &= r_rd[b];
  end
  always_comb begin
    out_pma = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (w_m[i]) out_pma = i[$clog2(ENTRIES)-1:0];
  end
  assign out_hit = |w_m;
endmodule

// File: tb/tb_tcam28x64_search_array.sv
// tb_tcam28x64_search_array: directed table plus randomized searches against an array-based TCAM model.
module tb_tcam28x64_search_array;
  logic        in_clk = 0;
  logic        in_rstn = 0;
  logic        in_csb = 1;
  logic        in_web = 1;
  logic [3:0]  in_wmask = '0;
  logic [27:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [5:0]  out_pma;
  logic        out_hit;

  tcam28x64_search_array dut (
    .in_clk(in_clk), .in_rstn(in_rstn), .in_csb(in_csb), .in_web(in_web),
    .in_wmask(in_wmask), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_pma(out_pma), .out_hit(out_hit)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    logic        csb;
    logic        web;
    logic [3:0]  mask;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [5:0]  pma;
    logic        hit;
  } vec_t;

  vec_t        tv[$];
  logic [63:0] model [4][128];
  logic [5:0]  exp_pma = 0;
  logic        exp_hit = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [5:0] e_pma, input logic e_hit);
    checks++;
    if (out_pma !== e_pma || out_hit !== e_hit) begin
      errors++;
      $display("FAIL %s: got pma=%0d hit=%0d, expected pma=%0d hit=%0d", name, out_pma, out_hit, e_pma, e_hit);
    end
  endtask

  task automatic model_search(input logic [27:0] key);
    logic [63:0] m;
    m = '1;
    for (int b = 0; b < 4; b++) m = m & model[b][key[7*b +: 7]];
    exp_pma = 0;
    exp_hit = 0;
    for (int i = 0; i < 64; i++)
      if (m[i] && !exp_hit) begin
        exp_pma = 6'(i);
        exp_hit = 1;
      end
  endtask

  task automatic do_op(input logic csb, input logic web, input logic [3:0] mask,
                       input logic [27:0] addr, input logic [31:0] data);
    @(negedge in_clk);
    in_csb = csb; in_web = web; in_wmask = mask; in_addr = addr; in_wdata = data;
    @(posedge in_clk);
    #1;
    in_csb = 1;
    if (in_rstn && !csb) begin
      if (web) model_search(addr);
      else
        for (int k = 0; k < 4; k++)
          if (mask[k]) model[addr[9:8]][addr[6:0]][32*addr[7] + 8*k +: 8] = data[8*k +: 8];
    end
  endtask

  task automatic add(input logic csb, input logic web, input logic [3:0] mask, input logic [27:0] addr,
                     input logic [31:0] data, input logic [5:0] pma, input logic hit);
    tv.push_back(vec_t'{csb, web, mask, addr, data, pma, hit});
  endtask

  initial begin
    logic [27:0] key;
    logic [6:0]  row;
    add(0, 0, 4'hF, 28'h000, 32'h20, 0, 0);
    add(0, 0, 4'hF, 28'h100, 32'h20, 0, 0);
    add(0, 0, 4'hF, 28'h200, 32'h20, 0, 0);
    add(0, 0, 4'hF, 28'h300, 32'h20, 0, 0);
    add(0, 1, 4'h0, 28'h0, 32'h0, 5, 1);
    add(0, 0, 4'hF, 28'h080, 32'h1, 5, 1);
    add(0, 0, 4'hF, 28'h180, 32'h1, 5, 1);
    add(0, 0, 4'hF, 28'h280, 32'h1, 5, 1);
    add(0, 0, 4'hF, 28'h380, 32'h1, 5, 1);
    add(0, 1, 4'h0, 28'h0, 32'h0, 5, 1);
    add(1, 0, 4'hF, 28'h000, 32'h0, 5, 1);
    add(0, 0, 4'hF, 28'h005, 32'h8, 5, 1);
    add(0, 0, 4'hF, 28'h103, 32'h8, 5, 1);
    add(0, 0, 4'hF, 28'h200, 32'h8, 5, 1);
    add(0, 0, 4'hF, 28'h300, 32'h8, 5, 1);
    add(0, 1, 4'h0, 28'h0000185, 32'h0, 3, 1);
    add(0, 1, 4'h0, 28'h0000186, 32'h0, 0, 0);
    add(0, 1, 4'h0, 28'h0000185, 32'h0, 3, 1);
    add(0, 0, 4'h2, 28'h010, 32'hFFFFFFFF, 3, 1);
    add(0, 0, 4'h2, 28'h110, 32'hFFFFFFFF, 3, 1);
    add(0, 0, 4'h2, 28'h210, 32'hFFFFFFFF, 3, 1);
    add(0, 0, 4'h2, 28'h310, 32'hFFFFFFFF, 3, 1);
    add(0, 1, 4'h0, 28'h2040810, 32'h0, 8, 1);
    add(1, 1, 4'h0, 28'h0000186, 32'h0, 8, 1);

    repeat (3) @(posedge in_clk);
    #1 check("reset_state", 0, 0);
    @(negedge in_clk);
    in_rstn = 1;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 256; r++) do_op(0, 0, 4'hF, 28'((b << 8) | r), 32'h0);
    check("idle_after_init", 0, 0);

    for (int i = 0; i < tv.size(); i++) begin
      do_op(tv[i].csb, tv[i].web, tv[i].mask, tv[i].addr, tv[i].wdata);
      check($sformatf("vec%0d", i), tv[i].pma, tv[i].hit);
    end

    @(negedge in_clk);
    in_rstn = 0;
    #1 check("async_reset_clears", 0, 0);
    do_op(0, 0, 4'hF, 28'h010, 32'h0);
    do_op(0, 1, 4'h0, 28'h2040810, 32'h0);
    check("ops_ignored_in_reset", 0, 0);
    @(negedge in_clk);
    in_rstn = 1;
    do_op(0, 1, 4'h0, 28'h2040810, 32'h0);
    check("search_after_release", 8, 1);

    for (int i = 0; i < 400; i++) begin
      row = 7'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        key = 28'({$urandom_range(0, 3), $urandom_range(0, 1)} << 7 | row);
        do_op(0, 0, 4'($urandom_range(0, 15)), key, $urandom | $urandom);
      end else if ($urandom_range(0, 5) == 0) begin
        do_op(1, $urandom_range(0, 1) == 1, 4'hF, 28'($urandom), $urandom);
      end else begin
        key = 0;
        for (int b = 0; b < 4; b++) key[7*b +: 7] = 7'($urandom_range(0, 7));
        do_op(0, 1, 4'h0, key, 32'h0);
      end
      check($sformatf("rand%0d", i), exp_pma, exp_hit);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
